// File: rtl/fas.sv
// Parameterizable full adder/subtractor slice with combinational results and a
// one-cycle registered copy. Define FAS_STICKY_OVF_EN to make ovf_q sticky until reset.
module fas #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             a_ns,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic [WIDTH-1:0] s_q,
  output logic             cout_q,
  output logic             ovf_q
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH:0]   res;
  logic [WIDTH-1:0] s_d;
  logic             cout_d;
  logic             ovf_d;

  // One extra bit holds the carry in add mode and the borrow in subtract mode,
  // since a negative difference sets the top bit of the WIDTH+1 result.
  always_comb begin
    res = '0;
    if (a_ns) begin
      res = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
    end else begin
      res = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    end
  end

  assign s    = res[WIDTH-1:0];
  assign cout = res[WIDTH];
  assign ovf  = (a_ns ? (a[MSB] != b[MSB]) : (a[MSB] == b[MSB])) && (s[MSB] != a[MSB]);

  assign s_d    = s;
  assign cout_d = cout;
`ifdef FAS_STICKY_OVF_EN
  assign ovf_d  = ovf_q | ovf;
`else
  assign ovf_d  = ovf;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      s_q    <= s_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
    end
  end

endmodule

// File: tb/tb_fas.sv
// Directed self-checking bench for fas: a WIDTH=1 cell and a WIDTH=8 slice share clock and reset.
module tb_fas;

  logic       clk = 1'b0;
  logic       rst;
  logic       a1, b1, cin1, ns1;
  logic       s1, cout1, ovf1, s_q1, cout_q1, ovf_q1;
  logic [7:0] a8, b8;
  logic       cin8, ns8;
  logic [7:0] s8, s_q8;
  logic       cout8, ovf8, cout_q8, ovf_q8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fas #(.WIDTH(1)) u_fas1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .cin(cin1), .a_ns(ns1),
    .s(s1), .cout(cout1), .ovf(ovf1), .s_q(s_q1), .cout_q(cout_q1), .ovf_q(ovf_q1)
  );

  fas #(.WIDTH(8)) u_fas8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .cin(cin8), .a_ns(ns8),
    .s(s8), .cout(cout8), .ovf(ovf8), .s_q(s_q8), .cout_q(cout_q8), .ovf_q(ovf_q8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic ns);
    a8 = a; b8 = b; cin8 = c; ns8 = ns;
    #1;
  endtask

  initial begin
    int ai, bi, ci, ni, r, es, ec, eo;
    logic [3:0] v;
    logic sticky_exp;
`ifdef FAS_STICKY_OVF_EN
    sticky_exp = 1'b1;
`else
    sticky_exp = 1'b0;
`endif
    rst = 1'b1;
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b0; ns1 = 1'b0;
    set8(8'h7F, 8'h01, 1'b0, 1'b0);

    // Reset held over an edge with nonzero inputs
    tick();
    chk("rst_s_q8", 64'(s_q8), 64'h00);
    chk("rst_cout_q8", 64'(cout_q8), 64'h0);
    chk("rst_ovf_q8", 64'(ovf_q8), 64'h0);
    chk("rst_cout_q1", 64'(cout_q1), 64'h0);
    chk("rst_comb_s8", 64'(s8), 64'h80);
    chk("rst_comb_ovf8", 64'(ovf8), 64'h1);
    chk("rst_comb_cout1", 64'(cout1), 64'h1);

    rst = 1'b0;
    tick();
    chk("load_s_q8", 64'(s_q8), 64'h80);
    chk("load_ovf_q8", 64'(ovf_q8), 64'h1);
    chk("load_cout_q8", 64'(cout_q8), 64'h0);

    // WIDTH=1: 1+1+0, then mode toggle
    chk("w1_add_s", 64'(s1), 64'h0);
    chk("w1_add_cout", 64'(cout1), 64'h1);
    chk("w1_add_s_q", 64'(s_q1), 64'h0);
    chk("w1_add_cout_q", 64'(cout_q1), 64'h1);
    ns1 = 1'b1; #1;
    chk("w1_sub_s", 64'(s1), 64'h0);
    chk("w1_sub_cout", 64'(cout1), 64'h0);
    chk("w1_sub_cout_q_held", 64'(cout_q1), 64'h1);
    ns1 = 1'b0; #1;
    chk("w1_back_s", 64'(s1), 64'h0);
    chk("w1_back_cout", 64'(cout1), 64'h1);

    // WIDTH=1 exhaustive sweep
    for (int i = 0; i < 16; i++) begin
      v = 4'(i);
      {a1, b1, cin1, ns1} = v;
      ai = int'(v[3]); bi = int'(v[2]); ci = int'(v[1]); ni = int'(v[0]);
      if (ni == 0) begin
        r  = ai + bi + ci;
        es = r & 1;
        ec = (r >> 1) & 1;
        eo = (ai == bi && es != ai) ? 1 : 0;
      end else begin
        r  = ai - bi - ci;
        es = r & 1;
        ec = (ai < bi + ci) ? 1 : 0;
        eo = (ai != bi && es != ai) ? 1 : 0;
      end
      #1;
      $display("sweep a=%0d b=%0d cin=%0d a_ns=%0d -> s=%0d cout=%0d ovf=%0d", ai, bi, ci, ni, s1, cout1, ovf1);
      chk($sformatf("sweep%0d_s", i), 64'(s1), 64'(es));
      chk($sformatf("sweep%0d_cout", i), 64'(cout1), 64'(ec));
      chk($sformatf("sweep%0d_ovf", i), 64'(ovf1), 64'(eo));
      tick();
      chk($sformatf("sweep%0d_s_q", i), 64'(s_q1), 64'(es));
      chk($sformatf("sweep%0d_cout_q", i), 64'(cout_q1), 64'(ec));
      chk($sformatf("sweep%0d_ovf_q", i), 64'(ovf_q1), 64'(eo));
    end

    // WIDTH=8 directed vectors
    set8(8'h00, 8'h01, 1'b0, 1'b1);
    chk("sub_0_1_s", 64'(s8), 64'hFF);
    chk("sub_0_1_cout", 64'(cout8), 64'h1);
    chk("sub_0_1_ovf", 64'(ovf8), 64'h0);
    set8(8'h80, 8'h01, 1'b0, 1'b1);
    chk("sub_80_1_s", 64'(s8), 64'h7F);
    chk("sub_80_1_cout", 64'(cout8), 64'h0);
    chk("sub_80_1_ovf", 64'(ovf8), 64'h1);
    set8(8'hFF, 8'hFF, 1'b1, 1'b0);
    chk("add_wrap_s", 64'(s8), 64'hFF);
    chk("add_wrap_cout", 64'(cout8), 64'h1);
    chk("add_wrap_ovf", 64'(ovf8), 64'h0);
    set8(8'h00, 8'h00, 1'b1, 1'b1);
    chk("sub_wrap_s", 64'(s8), 64'hFF);
    chk("sub_wrap_cout", 64'(cout8), 64'h1);
    tick();
    chk("sub_wrap_s_q", 64'(s_q8), 64'hFF);
    chk("sub_wrap_cout_q", 64'(cout_q8), 64'h1);
    set8(8'h10, 8'h20, 1'b0, 1'b1);
    chk("sub_10_20_s", 64'(s8), 64'hF0);
    chk("sub_10_20_cout", 64'(cout8), 64'h1);

    // Overflow stickiness (or plain delay) across non-overflowing ops
    rst = 1'b1; tick(); rst = 1'b0;
    chk("pre_ovf_q", 64'(ovf_q8), 64'h0);
    set8(8'h7F, 8'h01, 1'b0, 1'b0);
    tick();
    chk("ovf_set_q", 64'(ovf_q8), 64'h1);
    set8(8'h01, 8'h01, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("ovf_hold%0d", k), 64'(ovf_q8), 64'(sticky_exp));
      chk($sformatf("ovf_hold%0d_s_q", k), 64'(s_q8), 64'h02);
    end
    rst = 1'b1; tick(); rst = 1'b0;
    chk("ovf_clear_q", 64'(ovf_q8), 64'h0);
    chk("ovf_clear_s_q", 64'(s_q8), 64'h00);
    chk("ovf_clear_comb_s", 64'(s8), 64'h02);
    tick();
    chk("post_rst_load_s_q", 64'(s_q8), 64'h02);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
